// File: rtl/acc_pkg.sv
// acc_pkg: op/state types, NOP encoding and the accumulator update function shared with the ALU model
package acc_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, OR = 2'd2, XOR = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam op_t NOP_OP = OR;
  localparam logic [7:0] NOP_OPERAND = '0;
  function automatic logic [7:0] acc_apply(input logic [7:0] acc, input op_t op, input logic [7:0] operand);
    return op == ADD ? acc + operand : op == SUB ? acc - operand : op == OR ? acc | operand : acc ^ operand;
  endfunction
endpackage

// File: rtl/acc_prog_mem.sv
// acc_prog_mem: DEPTH x {op, operand} program regfile, one sync write port, one async read port
module acc_prog_mem #(
  parameter int DEPTH = 8,
  parameter int DW = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [1:0]    wop,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [1:0]    rop,
  output logic [DW-1:0] rd
);
  logic [DW+1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= {wop, wd};
  assign {rop, rd} = mem[ra];
endmodule

// File: rtl/acc_op_sequencer.sv
// acc_op_sequencer: runs a stored {op, operand} program into the accumulator ALU, NOP when idle.
// Optional ACC_SEQ_SHADOW_EN adds acc_shadow, a mirror of the ALU accumulator.
module acc_op_sequencer import acc_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int DW = 8,
  parameter int LOOPW = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_op,
  input  logic [DW-1:0]    wr_data,
  input  logic [AW:0]      prog_len,
  input  logic [LOOPW-1:0] loop_cnt,
  input  logic             start,
  input  logic             abort,
  output logic [1:0]       alu_op,
  output logic [DW-1:0]    alu_operand,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pc
`ifdef ACC_SEQ_SHADOW_EN
  , output logic [DW-1:0]  acc_shadow
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  seq_state_t state, state_n;
  logic [AW-1:0] pc_n;
  logic [AW:0] len, len_n, len_in;
  logic [LOOPW-1:0] pass, pass_n;
  logic [1:0] rop, op_sel;
  logic [DW-1:0] rd, dat_sel;
  logic we, wrap;
  assign we = wr_en && state == IDLE;
  acc_prog_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .clk(clk), .we(we), .wa(wr_addr), .wop(wr_op), .wd(wr_data),
    .ra(pc_n), .rop(rop), .rd(rd)
  );
  // Forward a same-cycle write so a start issued alongside it sees the new entry
  assign op_sel = we && wr_addr == pc_n ? wr_op : rop;
  assign dat_sel = we && wr_addr == pc_n ? wr_data : rd;
  always_comb begin
    len_in = prog_len > FULL ? FULL : prog_len;
    wrap = {1'b0, pc} == len - 1'b1;
    state_n = state;
    pc_n = '0;
    len_n = len;
    pass_n = pass;
    if (abort) state_n = IDLE;
    else if (state == IDLE && start) begin
      len_n = len_in;
      pass_n = loop_cnt;
      state_n = len_in == '0 ? DONE : RUN;
    end else if (state == RUN) begin
      state_n = wrap && pass == '0 ? DONE : RUN;
      pc_n = wrap || state_n == DONE ? '0 : pc + 1'b1;
      pass_n = wrap ? pass - 1'b1 : pass;
    end else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      len <= '0;
      pass <= '0;
      alu_op <= NOP_OP;
      alu_operand <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      len <= len_n;
      pass <= pass_n;
      alu_op <= state_n == RUN ? op_sel : NOP_OP;
      alu_operand <= state_n == RUN ? dat_sel : '0;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
`ifdef ACC_SEQ_SHADOW_EN
  always_ff @(posedge clk) acc_shadow <= rst ? '0 : acc_apply(acc_shadow, op_t'(alu_op), alu_operand);
`endif
endmodule

// File: tb/tb_acc_op_sequencer.sv
// tb_acc_op_sequencer: directed and randomized programs checked against a pass/entry model of the sequencer
module tb_acc_op_sequencer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  logic clk = 0, rst, wr_en, start, abort;
  logic [AW-1:0] wr_addr, pc;
  logic [1:0] wr_op, alu_op;
  logic [7:0] wr_data, alu_operand;
  logic [AW:0] prog_len;
  logic [3:0] loop_cnt;
  logic busy, done;
`ifdef ACC_SEQ_SHADOW_EN
  logic [7:0] acc_shadow;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [1:0] m_op [DEPTH];
  logic [7:0] m_dat [DEPTH];
  logic [1:0] eop;
  logic [7:0] eopnd, eacc;

  acc_op_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_data(wr_data),
    .prog_len(prog_len), .loop_cnt(loop_cnt), .start(start), .abort(abort),
    .alu_op(alu_op), .alu_operand(alu_operand), .busy(busy), .done(done), .pc(pc)
`ifdef ACC_SEQ_SHADOW_EN
    , .acc_shadow(acc_shadow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_apply(input logic [7:0] a, input logic [1:0] o, input logic [7:0] d);
    case (o)
      2'd0: return a + d;
      2'd1: return a - d;
      2'd2: return a | d;
      default: return a ^ d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model the accumulator with the outputs expected during the cycle that ends at this edge
  task automatic step;
    @(posedge clk);
    #1;
    eacc = rst ? 8'h00 : ref_apply(eacc, eop, eopnd);
  endtask

  task automatic chk_out(input string tag, input logic b, input logic d);
    chk({tag, ".op"}, 32'(alu_op), 32'(eop));
    chk({tag, ".operand"}, 32'(alu_operand), 32'(eopnd));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
`ifdef ACC_SEQ_SHADOW_EN
    chk({tag, ".shadow"}, 32'(acc_shadow), 32'(eacc));
`endif
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] o, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_op = o; wr_data = d;
    step;
    wr_en = 0;
    m_op[a] = o; m_dat[a] = d;
  endtask

  task automatic nop_expect;
    eop = 2'd2; eopnd = 8'h00;
  endtask

  // Run len entries for loops+1 passes; optionally kill at issue cycle kill_k, or poke write/start at cycle 1
  task automatic run(input int len, input int loops, input int kill_k, input bit kill_rst, input bit poke);
    int n = len > DEPTH ? DEPTH : len;
    int total = n * (loops + 1);
    prog_len = len[AW:0]; loop_cnt = loops[3:0]; start = 1;
    step;
    start = 0; wr_en = 0;
    if (n == 0) begin
      nop_expect;
      chk_out("zero_len", 0, 1);
      step;
      chk_out("zero_len_after", 0, 0);
      return;
    end
    for (int k = 0; k < total; k++) begin
      eop = m_op[k % n]; eopnd = m_dat[k % n];
      chk_out("issue", 1, 0);
      chk("issue.pc", 32'(pc), 32'(k % n));
      if (poke && k == 1) begin
        wr_en = 1; wr_addr = 0; wr_op = 2'd0; wr_data = 8'h10; start = 1;
      end else begin
        wr_en = 0; start = 0;
      end
      if (k == kill_k) begin
        if (kill_rst) rst = 1; else abort = 1;
        step;
        rst = 0; abort = 0; wr_en = 0; start = 0;
        nop_expect;
        chk_out("kill", 0, 0);
        if (kill_rst) chk("kill.pc", 32'(pc), 32'd0);
        step;
        chk_out("kill_after", 0, 0);
        return;
      end
      step;
    end
    wr_en = 0; start = 0;
    nop_expect;
    chk_out("done", 0, 1);
    step;
    chk_out("idle", 0, 0);
  endtask

  initial begin
    rst = 1; wr_en = 0; start = 0; abort = 0; wr_addr = '0; wr_op = '0; wr_data = '0;
    prog_len = '0; loop_cnt = '0; eacc = 8'h00;
    nop_expect;
    step;
    step;
    rst = 0;
    chk_out("reset", 0, 0);
    chk("reset.pc", 32'(pc), 32'd0);
    wr(0, 2'd0, 8'h05);
    wr(1, 2'd1, 8'h02);
    wr(2, 2'd3, 8'hFF);
    run(3, 0, -1, 0, 0);
`ifdef ACC_SEQ_SHADOW_EN
    chk("prog3.shadow", 32'(acc_shadow), 32'h0FC);
`endif
    run(3, 2, -1, 0, 0);
    run(0, 0, -1, 0, 0);
    wr(3, 2'd0, 8'h07);
    run(4, 0, 1, 0, 0);
    start = 1; abort = 1;
    step;
    start = 0; abort = 0;
    chk_out("start_abort", 0, 0);
    step;
    chk_out("start_abort_after", 0, 0);
    run(3, 0, -1, 0, 1);
    run(3, 0, -1, 0, 0);
    wr_en = 1; wr_addr = 0; wr_op = 2'd3; wr_data = 8'h5A;
    m_op[0] = 2'd3; m_dat[0] = 8'h5A;
    run(2, 1, -1, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr(3'(i), 2'($urandom_range(0, 3)), 8'($urandom));
    run(13, 0, -1, 0, 0);
    run(8, 1, -1, 0, 0);
    run(5, 1, 6, 1, 0);
    for (int it = 0; it < 40; it++) begin
      int len, loops, kk;
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        wr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom));
      len = $urandom_range(0, 15);
      loops = $urandom_range(0, 3);
      kk = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 20)) : -1;
      run(len, loops, kk, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
